// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared defaults and helpers for the memory port arbiter
// Purpose: default memory geometry and the client-id width helper.
// Ports: none (package).
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 64;

  // Width needed to hold an index in 0..n-1, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - client and memory side bundle of the memory port arbiter
// Purpose: groups the read/write request, read response and memory port signals.
// Modports:
//   slave  - arbiter view: takes requests and memory read data, drives grants,
//            responses and the memory read/write port
//   master - client/memory view, the mirror of slave
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [NUM_RD-1:0]        rd_req_valid;
  logic [NUM_RD*ADDR_W-1:0] rd_req_addr;
  logic [NUM_RD-1:0]        rd_req_ready;
  logic [NUM_RD-1:0]        rd_resp_valid;
  logic [DATA_W-1:0]        rd_resp_data;

  logic [NUM_WR-1:0]        wr_req_valid;
  logic [NUM_WR*ADDR_W-1:0] wr_req_addr;
  logic [NUM_WR*DATA_W-1:0] wr_req_data;
  logic [NUM_WR-1:0]        wr_req_ready;

  logic [ADDR_W-1:0]        mem_raddr;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_wen;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]        mem_wdata;

  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, mem_rdata,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
           mem_raddr, mem_wen, mem_waddr, mem_wdata
  );

  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, mem_rdata,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready,
           mem_raddr, mem_wen, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating priority pointer
// Purpose: one-hot grant among N requesters, search starts at the pointer and wraps.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset, clears the pointer to 0
//   valid - per-requester request vector
//   grant - one-hot grant (combinational), zero when nothing requests
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);

  localparam int PTR_W = clog2(N);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk offsets 0..N-1 from the pointer; the first requester hit wins and
  // the pointer moves just past it. No hit leaves the pointer untouched.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
      idx = sum[PTR_W-1:0];
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == PTR_W'(N-1)) ? '0 : PTR_W'(idx + 1'b1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares a 1R1W synchronous memory among read and write clients
// Purpose: independent round-robin arbitration on the read and write ports, read
//   responses tagged to the issuing client, same-cycle write-to-read forwarding.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - slave modport: client requests/grants, read responses, memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int RD_ID_W = clog2(NUM_RD);

  logic [NUM_RD-1:0]  rd_grant_raw;
  logic [NUM_WR-1:0]  wr_grant_raw;
  logic [NUM_RD-1:0]  rd_gnt;
  logic [NUM_WR-1:0]  wr_gnt;

  logic               rd_issue;
  logic [RD_ID_W-1:0] rd_id;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wr_fire;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               collide;

  logic               issue_q;
  logic [RD_ID_W-1:0] id_q;
  logic [ADDR_W-1:0]  raddr_q;
  logic               fwd_valid_q;
  logic [DATA_W-1:0]  fwd_data_q;

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clock (clock),
    .reset (reset),
    .valid (bus.rd_req_valid),
    .grant (rd_grant_raw)
  );

  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clock (clock),
    .reset (reset),
    .valid (bus.wr_req_valid),
    .grant (wr_grant_raw)
  );

  // Grants and the write strobe are held low for as long as reset is low,
  // not just from the next edge.
  assign rd_gnt = rd_grant_raw & {NUM_RD{reset}};
  assign wr_gnt = wr_grant_raw & {NUM_WR{reset}};

  always_comb begin
    rd_issue = |rd_gnt;
    rd_id    = '0;
    rd_addr  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_gnt[i]) begin
        rd_id   = RD_ID_W'(i);
        rd_addr = bus.rd_req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    wr_fire = |wr_gnt;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_gnt[i]) begin
        wr_addr = bus.wr_req_addr[i*ADDR_W +: ADDR_W];
        wr_data = bus.wr_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // The macro's read-during-write result is undefined, so a read colliding
  // with a same-cycle write returns the write data instead (write-first).
  assign collide = rd_issue && wr_fire && (rd_addr == wr_addr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_q     <= 1'b0;
      id_q        <= '0;
      raddr_q     <= '0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      issue_q     <= rd_issue;
      fwd_valid_q <= collide;
      if (rd_issue) begin
        id_q    <= rd_id;
        raddr_q <= rd_addr;
      end
      if (collide) fwd_data_q <= wr_data;
    end
  end

  assign bus.rd_req_ready = rd_gnt;
  assign bus.wr_req_ready = wr_gnt;
  // Idle read cycles keep presenting the last issued address to the macro.
  assign bus.mem_raddr    = rd_issue ? rd_addr : raddr_q;
  assign bus.mem_wen      = wr_fire;
  assign bus.mem_waddr    = wr_addr;
  assign bus.mem_wdata    = wr_data;
  assign bus.rd_resp_data = fwd_valid_q ? fwd_data_q : bus.mem_rdata;

  always_comb begin
    bus.rd_resp_valid = '0;
    if (issue_q) bus.rd_resp_valid[id_q] = 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic [1:0]  vmask;
    logic [63:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [63:0] mem_arr [0:31];
  logic [63:0] ref_mem [0:31];
  logic        load_en   = 1'b0;
  logic [4:0]  load_addr = 5'd0;
  logic [63:0] load_data = 64'd0;

  // Memory macro model: registered read address, one-cycle read latency.
  always @(posedge clock) begin
    if (load_en) mem_arr[load_addr] <= load_data;
    else if (bus.mem_wen) mem_arr[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_arr[bus.mem_raddr];
  end

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] m, input logic [63:0] d);
    exp_t e;
    e.vmask = m;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_rd(input logic [1:0] v, input logic [4:0] a1, input logic [4:0] a0);
    bus.rd_req_valid = v;
    bus.rd_req_addr  = {a1, a0};
  endtask

  task automatic drive_wr(input logic [1:0] v, input logic [4:0] a1, input logic [4:0] a0,
                          input logic [63:0] d1, input logic [63:0] d0);
    bus.wr_req_valid = v;
    bus.wr_req_addr  = {a1, a0};
    bus.wr_req_data  = {d1, d0};
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_grants(input logic [1:0] rd_exp, input logic [1:0] wr_exp, input logic wen_exp);
    chk("rd_req_ready", 64'(bus.rd_req_ready), 64'(rd_exp));
    chk("wr_req_ready", 64'(bus.wr_req_ready), 64'(wr_exp));
    chk("mem_wen", 64'(bus.mem_wen), 64'(wen_exp));
  endtask

  task automatic mon_step();
    exp_t e;
    if (bus.rd_resp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_resp_unexpected: actual=%b expected=none", bus.rd_resp_valid);
      end else begin
        e = exp_q.pop_front();
        chk("rd_resp_valid", 64'(bus.rd_resp_valid), 64'(e.vmask));
        chk("rd_resp_data", bus.rd_resp_data, e.data);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clock);
          mon_step();
        end
      end
      begin : stimulus
        drive_rd(2'b00, 5'd0, 5'd0);
        drive_wr(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
        ref_mem[7]  = 64'h0000_0000_0000_00AA;
        ref_mem[8]  = 64'h0000_0000_0000_00BB;
        ref_mem[10] = 64'h1010_1010_1010_1010;
        ref_mem[11] = 64'h1111_2222_3333_4444;

        // Reset held: preload memory while every client requests; nothing granted.
        for (int i = 0; i < 4; i++) begin
          next_cycle();
          load_en = 1'b1;
          case (i)
            0: load_addr = 5'd7;
            1: load_addr = 5'd8;
            2: load_addr = 5'd10;
            default: load_addr = 5'd11;
          endcase
          load_data = ref_mem[load_addr];
          drive_rd(2'b11, 5'd1, 5'd2);
          drive_wr(2'b11, 5'd1, 5'd2, 64'd1, 64'd2);
          @(negedge clock);
          chk_grants(2'b00, 2'b00, 1'b0);
        end
        next_cycle();
        load_en = 1'b0;
        drive_rd(2'b00, 5'd0, 5'd0);
        drive_wr(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        reset = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
          @(negedge clock);
          chk_grants(2'b00, 2'b00, 1'b0);
          chk("idle_resp_valid", 64'(bus.rd_resp_valid), 64'd0);
          next_cycle();
        end

        // Write then read-after-write from the other read client.
        drive_wr(2'b01, 5'd0, 5'd3, 64'd0, 64'hDEAD_BEEF_0000_0001);
        @(negedge clock);
        chk_grants(2'b00, 2'b01, 1'b1);
        chk("mem_waddr", 64'(bus.mem_waddr), 64'd3);
        chk("mem_wdata", bus.mem_wdata, 64'hDEAD_BEEF_0000_0001);
        ref_mem[3] = 64'hDEAD_BEEF_0000_0001;
        next_cycle();
        drive_wr(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive_rd(2'b10, 5'd3, 5'd0);
        @(negedge clock);
        chk_grants(2'b10, 2'b00, 1'b0);
        chk("mem_raddr", 64'(bus.mem_raddr), 64'd3);
        push_exp(2'b10, ref_mem[3]);
        next_cycle();

        // Both read clients continuously: grants alternate from client 0.
        drive_rd(2'b11, 5'd11, 5'd10);
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          if (k % 2 == 0) begin
            chk_grants(2'b01, 2'b00, 1'b0);
            chk("mem_raddr", 64'(bus.mem_raddr), 64'd10);
            push_exp(2'b01, ref_mem[10]);
          end else begin
            chk_grants(2'b10, 2'b00, 1'b0);
            chk("mem_raddr", 64'(bus.mem_raddr), 64'd11);
            push_exp(2'b10, ref_mem[11]);
          end
          next_cycle();
        end

        // Collision: write addr 7 and read addr 7 in the same cycle.
        drive_rd(2'b01, 5'd0, 5'd7);
        drive_wr(2'b10, 5'd7, 5'd0, 64'h55, 64'd0);
        @(negedge clock);
        chk_grants(2'b01, 2'b10, 1'b1);
        chk("mem_raddr", 64'(bus.mem_raddr), 64'd7);
        chk("mem_waddr", 64'(bus.mem_waddr), 64'd7);
        push_exp(2'b01, 64'h55);
        ref_mem[7] = 64'h55;
        next_cycle();
        // Different addresses: memory data, no forwarding.
        drive_rd(2'b01, 5'd0, 5'd8);
        drive_wr(2'b10, 5'd7, 5'd0, 64'h77, 64'd0);
        @(negedge clock);
        chk_grants(2'b01, 2'b10, 1'b1);
        push_exp(2'b01, ref_mem[8]);
        ref_mem[7] = 64'h77;
        next_cycle();
        // Read the cycle after a write to the same address.
        drive_wr(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        drive_rd(2'b01, 5'd0, 5'd7);
        @(negedge clock);
        chk_grants(2'b01, 2'b00, 1'b0);
        push_exp(2'b01, ref_mem[7]);
        next_cycle();
        // No read: address holds.
        drive_rd(2'b00, 5'd0, 5'd0);
        @(negedge clock);
        chk_grants(2'b00, 2'b00, 1'b0);
        chk("mem_raddr_hold", 64'(bus.mem_raddr), 64'd7);
        next_cycle();

        // Both write clients for 4 cycles, addrs 0..3.
        for (int k = 0; k < 4; k++) begin
          drive_wr(2'b11, 5'(k), 5'(k), 64'hC1C1_0000_0000_0000 | 64'(k),
                   64'hC0C0_0000_0000_0000 | 64'(k));
          @(negedge clock);
          if (k % 2 == 0) begin
            chk_grants(2'b00, 2'b01, 1'b1);
            chk("mem_wdata", bus.mem_wdata, 64'hC0C0_0000_0000_0000 | 64'(k));
            ref_mem[k] = 64'hC0C0_0000_0000_0000 | 64'(k);
          end else begin
            chk_grants(2'b00, 2'b10, 1'b1);
            chk("mem_wdata", bus.mem_wdata, 64'hC1C1_0000_0000_0000 | 64'(k));
            ref_mem[k] = 64'hC1C1_0000_0000_0000 | 64'(k);
          end
          chk("mem_waddr", 64'(bus.mem_waddr), 64'(k));
          next_cycle();
        end
        drive_wr(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        for (int k = 0; k < 4; k++) begin
          drive_rd(2'b01, 5'd0, 5'(k));
          @(negedge clock);
          chk_grants(2'b01, 2'b00, 1'b0);
          push_exp(2'b01, ref_mem[k]);
          next_cycle();
        end

        // Reset in the cycle after a read grant drops the response.
        drive_rd(2'b01, 5'd0, 5'd10);
        @(negedge clock);
        chk_grants(2'b01, 2'b00, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive_rd(2'b00, 5'd0, 5'd0);
        @(negedge clock);
        chk("resp_dropped", 64'(bus.rd_resp_valid), 64'd0);
        next_cycle();
        drive_rd(2'b11, 5'd11, 5'd10);
        @(negedge clock);
        chk_grants(2'b00, 2'b00, 1'b0);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        chk_grants(2'b01, 2'b00, 1'b0);
        push_exp(2'b01, ref_mem[10]);
        next_cycle();
        @(negedge clock);
        chk_grants(2'b10, 2'b00, 1'b0);
        push_exp(2'b10, ref_mem[11]);
        next_cycle();
        drive_rd(2'b00, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) next_cycle();
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
